// File: rtl/distributor_pkg.sv
// Shared types and helpers for the distributor: FSM encoding, default sizes
// and a width helper that never returns zero.
package distributor_pkg;

    typedef enum logic [1:0] {
        DIST_RECEIVE  = 2'd0,
        DIST_DISPATCH = 2'd1
    } dist_state_e;

    localparam int DIST_NUM_ENCRYPTERS  = 4;
    localparam int DIST_ENCRYPTER_WIDTH = 32;
    localparam int DIST_NIBBLE_W        = 4;

    // Counter/index width; a one-entry range still needs a 1-bit register.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/distributor_qspi_deserializer.sv
// Nibble shift register and nibble counter; flags the edge on which the
// final nibble of a word is accepted.
module distributor_qspi_deserializer
    import distributor_pkg::*;
#(
    parameter int WORD_W = DIST_ENCRYPTER_WIDTH,
    parameter int CNT_W  = clog2_min1(DIST_ENCRYPTER_WIDTH / DIST_NIBBLE_W)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     shift_en_i,
    input  logic [DIST_NIBBLE_W-1:0] nibble_i,
    output logic [WORD_W-1:0]        word_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     word_done_o
);

    localparam int NIBBLES = WORD_W / DIST_NIBBLE_W;

    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_nibble;

    assign last_nibble = (count_q == CNT_W'(NIBBLES - 1));
    assign word_done_o = shift_en_i && last_nibble;
    assign word_o      = word_q;
    assign count_o     = count_q;

    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (shift_en_i) begin
            // Shift form also works for a single-nibble word.
            word_d  = (word_q << DIST_NIBBLE_W) | WORD_W'(nibble_i);
            count_d = last_nibble ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/distributor.sv
// Assembles QSPI nibbles into words and hands each word to the encrypter
// lanes in strict round-robin order, stalling until the target lane is ready.
module distributor
    import distributor_pkg::*;
#(
    parameter int  NUM_ENCRYPTERS   = DIST_NUM_ENCRYPTERS,
    parameter int  ENCRYPTER_WIDTH  = DIST_ENCRYPTER_WIDTH,
    localparam int NIBBLES_PER_WORD = ENCRYPTER_WIDTH / DIST_NIBBLE_W,
    localparam int CNT_W            = clog2_min1(NIBBLES_PER_WORD),
    localparam int IDX_W            = clog2_min1(NUM_ENCRYPTERS)
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic [DIST_NIBBLE_W-1:0]                        qspi_data_i,
    input  logic                                            qspi_valid_i,
    output logic                                            qspi_ready_o,
    output logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]  encrypters_data_o,
    input  logic [NUM_ENCRYPTERS-1:0]                       encrypters_ready_i,
    output logic [NUM_ENCRYPTERS-1:0]                       encrypters_load_o,
    output logic [1:0]                                      state_out_o,
    output logic [ENCRYPTER_WIDTH-1:0]                      word_out_o,
    output logic [CNT_W-1:0]                                nibble_count_out_o,
    output logic [IDX_W-1:0]                                index_out_o
);

    dist_state_e state_q, state_d;
    logic [IDX_W-1:0]                                 index_q, index_d;
    logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]   lanes_q, lanes_d;
    logic [NUM_ENCRYPTERS-1:0]                        load_q, load_d;

    logic                       shift_en;
    logic                       word_done;
    logic [ENCRYPTER_WIDTH-1:0] word;
    logic [CNT_W-1:0]           nibble_count;

    assign qspi_ready_o = (state_q == DIST_RECEIVE);
    assign shift_en     = qspi_valid_i && qspi_ready_o;

    distributor_qspi_deserializer #(
        .WORD_W (ENCRYPTER_WIDTH),
        .CNT_W  (CNT_W)
    ) u_deser (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .shift_en_i  (shift_en),
        .nibble_i    (qspi_data_i),
        .word_o      (word),
        .count_o     (nibble_count),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        lanes_d = lanes_q;
        load_d  = '0;
        case (state_q)
            DIST_RECEIVE: begin
                if (word_done) state_d = DIST_DISPATCH;
            end
            DIST_DISPATCH: begin
                // No lane skipping: word order must match lane order downstream.
                if (encrypters_ready_i[index_q]) begin
                    lanes_d[index_q] = word;
                    load_d[index_q]  = 1'b1;
                    index_d          = (index_q == IDX_W'(NUM_ENCRYPTERS - 1))
                                       ? '0 : index_q + IDX_W'(1);
                    state_d          = DIST_RECEIVE;
                end
            end
            default: state_d = DIST_RECEIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= DIST_RECEIVE;
            index_q <= '0;
            lanes_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            lanes_q <= lanes_d;
            load_q  <= load_d;
        end
    end

    assign encrypters_data_o  = lanes_q;
    assign encrypters_load_o  = load_q;
    assign state_out_o        = state_q;
    assign word_out_o         = word;
    assign nibble_count_out_o = nibble_count;
    assign index_out_o        = index_q;

endmodule

// File: tb/tb_distributor.sv
// Self-checking bench for distributor: directed scenarios plus a randomized
// phase, all compared every cycle against a word-level reference model.
module tb_distributor;

    localparam int NE  = 4;
    localparam int W   = 32;
    localparam int NPW = W / 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [3:0]              qspi_data;
    logic                    qspi_valid;
    logic                    qspi_ready;
    logic [NE-1:0][W-1:0]    enc_data;
    logic [NE-1:0]           enc_ready;
    logic [NE-1:0]           enc_load;
    logic [1:0]              state_out;
    logic [W-1:0]            word_out;
    logic [2:0]              nib_cnt;
    logic [1:0]              index_out;

    always #5 clk = ~clk;

    distributor #(.NUM_ENCRYPTERS(NE), .ENCRYPTER_WIDTH(W)) dut (
        .clk_i              (clk),
        .reset_i            (reset_n),
        .qspi_data_i        (qspi_data),
        .qspi_valid_i       (qspi_valid),
        .qspi_ready_o       (qspi_ready),
        .encrypters_data_o  (enc_data),
        .encrypters_ready_i (enc_ready),
        .encrypters_load_o  (enc_load),
        .state_out_o        (state_out),
        .word_out_o         (word_out),
        .nibble_count_out_o (nib_cnt),
        .index_out_o        (index_out)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a word is either being collected or waiting for its lane.
    bit                   m_pend;
    int                   m_cnt;
    logic [W-1:0]         m_word;
    int                   m_idx;
    logic [NE-1:0][W-1:0] m_lane;
    logic [NE-1:0]        m_load;
    logic [NE-1:0]        prev_load = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_pend = 0; m_cnt = 0; m_word = '0; m_idx = 0; m_lane = '0; m_load = '0;
            end else begin
                m_load = '0;
                if (!m_pend) begin
                    if (qspi_valid) begin
                        m_word = {m_word[W-5:0], qspi_data};
                        m_cnt++;
                        if (m_cnt == NPW) begin
                            m_cnt  = 0;
                            m_pend = 1;
                        end
                    end
                end else if (enc_ready[m_idx]) begin
                    m_lane[m_idx] = m_word;
                    m_load[m_idx] = 1'b1;
                    m_idx  = (m_idx + 1) % NE;
                    m_pend = 0;
                end
            end
            #1;
            chk("qspi_ready", 128'(qspi_ready), 128'(!m_pend));
            chk("state", 128'(state_out), 128'(m_pend ? 1 : 0));
            chk("nibble_count", 128'(nib_cnt), 128'(m_cnt));
            chk("word_out", 128'(word_out), 128'(m_word));
            chk("index", 128'(index_out), 128'(m_idx));
            chk("load", 128'(enc_load), 128'(m_load));
            chk("lanes", 128'(enc_data), 128'(m_lane));
            chk("load_spacing", 128'(prev_load & enc_load), 128'(0));
            prev_load = enc_load;
        end
    end

    task automatic cyc(input bit v, input logic [3:0] d, input logic [NE-1:0] r, output bit consumed);
        bit rdy_snap;
        @(negedge clk);
        qspi_valid = v;
        qspi_data  = d;
        enc_ready  = r;
        rdy_snap   = qspi_ready;
        @(posedge clk);
        consumed = v && rdy_snap && reset_n;
    endtask

    task automatic idle(input int n, input logic [NE-1:0] r);
        bit c;
        for (int i = 0; i < n; i++) cyc(1'b0, 4'($urandom), r, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        qspi_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // pct: chance (percent) of valid each cycle; alt forces valid on every other cycle.
    task automatic send_word(input logic [W-1:0] w, input int k0, input int pct, input bit alt,
                             input logic [NE-1:0] r, input bit rand_rdy);
        int  k     = k0;
        int  guard = 0;
        bit  tog   = 1'b1;
        bit  v, c;
        logic [NE-1:0] rr;
        while (k < NPW) begin
            v  = alt ? tog : ($urandom_range(99) < pct);
            tog = ~tog;
            rr = rand_rdy ? NE'($urandom) : r;
            cyc(v, v ? w[W-1-4*k -: 4] : 4'($urandom), rr, c);
            if (c) k++;
            guard++;
            if (guard > 2000) begin
                total++;
                $display("FAIL send_timeout: actual=%0d nibbles required=%0d", k, NPW);
                break;
            end
        end
    endtask

    initial begin
        bit c;
        int nb;
        logic [W-1:0] w;
        reset_n    = 1'b0;
        qspi_valid = 1'b0;
        qspi_data  = 4'h0;
        enc_ready  = 4'hF;
        do_reset();

        // 1: first word, lane 0
        send_word(32'h12345678, 0, 100, 0, 4'hF, 0);
        cyc(1'b0, 4'h0, 4'hF, c);
        #2;
        chk("t1_load", 128'(enc_load), 128'(4'b0001));
        chk("t1_lane0", 128'(enc_data[0]), 128'(32'h12345678));
        chk("t1_index", 128'(index_out), 128'(1));

        // 2: lane 1 not ready, stall for 20 cycles
        send_word(32'hDEADBEEF, 0, 100, 0, 4'hD, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'h9, 4'hD, c);
            chk("t2_no_consume", 128'(c), 128'(0));
        end
        cyc(1'b0, 4'h0, 4'hF, c);
        #2;
        chk("t2_load", 128'(enc_load), 128'(4'b0010));
        chk("t2_lane1", 128'(enc_data[1]), 128'(32'hDEADBEEF));
        chk("t2_lane0", 128'(enc_data[0]), 128'(32'h12345678));

        // 3: five words wrap the index
        do_reset();
        for (int i = 1; i <= 5; i++) send_word(W'(i), 0, 100, 0, 4'hF, 0);
        idle(1, 4'hF);
        #2;
        chk("t3_lanes", 128'(enc_data), {32'd4, 32'd3, 32'd2, 32'd5});
        chk("t3_index", 128'(index_out), 128'(1));

        // 4: valid every other cycle
        send_word(32'hCAFEF00D, 0, 0, 1, 4'hF, 0);
        idle(1, 4'hF);
        #2;
        chk("t4_lane1", 128'(enc_data[1]), 128'(32'hCAFEF00D));

        // 5: reset after three nibbles
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 1), 4'hF, c);
        do_reset();
        #2;
        chk("t5_count", 128'(nib_cnt), 128'(0));
        chk("t5_index", 128'(index_out), 128'(0));
        chk("t5_lanes", 128'(enc_data), 128'(0));
        send_word(32'hA5A5A5A5, 0, 100, 0, 4'hF, 0);
        idle(1, 4'hF);
        #2;
        chk("t5_lane0", 128'(enc_data), {32'd0, 32'd0, 32'd0, 32'hA5A5A5A5});

        // 6: continuous valid, exactly one bubble between words
        w = 32'h0BADF00D;
        send_word(w, 0, 100, 0, 4'hF, 0);
        for (int j = 0; j < 4; j++) begin
            w  = $urandom;
            nb = 0;
            c  = 1'b0;
            while (!c && nb < 50) begin
                cyc(1'b1, w[W-1 -: 4], 4'hF, c);
                if (!c) nb++;
            end
            chk("t6_bubble", 128'(nb), 128'(1));
            send_word(w, 1, 100, 0, 4'hF, 0);
        end

        // random phase
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(19) == 0) do_reset();
            send_word($urandom, 0, $urandom_range(100, 30), 0, 4'hF, 1);
        end
        idle(5, 4'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
